md5_core_arbiter: RTL and testbench
===================================

Name: md5_core_arbiter

Overview:
- Shares one pancham MD5 core between NUM_REQ candidate generators (BruteForce instances) using round-robin arbitration.
- Issues one word at a time to the core and waits for the digest.
- Compares the digest against the target hash, counts hashes, and latches the first match.
- Replaces the ad-hoc enable/ready handshake currently in the controller when the design scales to several generators per core.

Parameters:
- NUM_REQ, 4, number of requesters; must be 2..16.
- TIMEOUT, 1024, maximum cycles to wait for core_out_valid after issue.
- IDW, 4, width of requester index; must satisfy 2^IDW >= NUM_REQ.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- req_valid  in  NUM_REQ  per-requester candidate valid.
- req_word  in  NUM_REQ*128  candidate words; slot i at bits [i*128 +: 128], MSB-first ([0:127] ordering).
- req_len  in  NUM_REQ*8  candidate length in bytes, per slot.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- target_hash  in  128  digest to match; held stable while running.
- clear  in  1  leaves DONE/ERROR and returns to IDLE.
- core_word  out  128  to pancham msg_in.
- core_width  out  8  to pancham msg_in_width.
- core_in_valid  out  1  to pancham msg_in_valid; single-cycle pulse.
- core_ready  in  1  pancham ready.
- core_digest  in  128  pancham msg_output.
- core_out_valid  in  1  pancham msg_out_valid.
- found  out  1  match latched.
- found_word  out  128  matching plaintext.
- found_len  out  8  matching plaintext length.
- found_id  out  IDW  requester that produced the match.
- last_digest  out  128  most recent digest (debug).
- hash_count  out  32  digests compared; wraps mod 2^32.
- busy  out  1  high in ISSUE, WAIT or COMPARE.
- timeout_err  out  1  sticky; core failed to answer within TIMEOUT.
- len_err  out  1  sticky; a rejected length was seen.

Behaviour:
- Reset values:
  - state = IDLE; round-robin pointer = 0.
  - req_ready, core_in_valid, found, timeout_err, len_err, busy = 0.
  - found_word, found_len, found_id, last_digest, hash_count, core_word, core_width = 0.
- States: IDLE, ISSUE, WAIT, COMPARE, DONE, ERROR.
- IDLE:
  - Grant is possible only when core_ready = 1.
  - Search req_valid starting at index ptr+1 mod NUM_REQ, wrapping; the first valid index g wins.
  - req_ready[g] is asserted combinationally in that same cycle; at most one bit is ever high.
  - On the transfer edge: capture word, len and g; set ptr <= g; go to ISSUE.
  - If the captured len is 0 or greater than 16: set len_err, drop the word, stay in IDLE, and leave hash_count unchanged. ptr still advances, so a faulty requester cannot monopolise the core.
- ISSUE:
  - Drive core_word and core_width from the captured values with core_in_valid = 1 for exactly one cycle.
  - Next state WAIT; clear the timeout counter.
- WAIT:
  - Increment the timeout counter each cycle.
  - On core_out_valid: register core_digest into last_digest and go to COMPARE.
  - If the counter reaches TIMEOUT-1 without core_out_valid: set timeout_err and go to ERROR.
  - If core_out_valid arrives in the same cycle the counter hits its limit, core_out_valid wins.
- COMPARE (one cycle):
  - hash_count += 1.
  - If last_digest == target_hash (full 128-bit compare): set found and latch found_word, found_len, found_id from the captured values; next state DONE.
  - Otherwise next state IDLE.
- Latency: grant-to-digest = 1 (ISSUE) + core latency + 1 (COMPARE). Back-to-back grants are spaced by at least core latency + 3 cycles.
- DONE: req_ready held at 0 and found held at 1; core_out_valid is ignored. clear -> IDLE, clearing found and the found_* outputs.
- ERROR: req_ready held at 0. clear -> IDLE, clearing timeout_err and len_err. clear has no effect in any other state.
- Any core_out_valid received outside WAIT is ignored and not counted.
- reset asserted in any state, including WAIT, aborts the in-flight word and applies the reset values on the next edge. The core's own reset is driven from the same reset net at top level.
- A req_valid that drops before it is granted is not an error.

Decomposition:
- Shared package md5_pkg holds:
  - state encoding enum;
  - constants MD5_WORD_W = 128, MD5_LEN_W = 8, MD5_MAX_LEN = 16.
- One natural sub-module: rr_arbiter. It is combinational and takes req, ptr and enable, returning a one-hot grant and a binary index.
- Keep it separate so the controller and any future multi-core scheduler reuse it.

Test Plan:
- NUM_REQ = 4, only req 2 valid with "abc" (len 3), target = 900150983cd24fb0d6963f7d28e17f72, core model latency 64:
  - one grant to req 2;
  - core_in_valid pulses once;
  - found = 1, found_id = 2, found_len = 3, hash_count = 1.
- All 4 requesters continuously valid with non-matching words, 12 transactions:
  - grant order 1,2,3,0,1,2,3,0,1,2,3,0;
  - req_ready never has 2 bits set;
  - hash_count = 12.
- Core model withholds core_out_valid, TIMEOUT = 16:
  - timeout_err = 1 exactly 16 cycles after the ISSUE cycle;
  - state ERROR, req_ready = 0;
  - clear returns to IDLE with timeout_err = 0.
- req 0 offers len 17, req 1 offers len 5 (valid):
  - len_err = 1; req 0's word is never hashed;
  - req 1 is hashed next; hash_count = 1.
- reset pulsed for 1 cycle during WAIT:
  - all outputs return to reset values the next cycle;
  - a late core_out_valid is ignored and hash_count stays 0.
- Match found, requesters keep valid for 50 cycles:
  - req_ready = 0 throughout and found_* stable;
  - clear then resumes granting from ptr+1.

Source files
------------

// File: rtl/md5_core_arbiter_pkg.sv
// md5_pkg: shared types and constants for the MD5 core arbiter.
// Holds the controller state encoding and word/length sizing.
package md5_pkg;

  localparam int MD5_WORD_W  = 128;
  localparam int MD5_LEN_W   = 8;
  localparam int MD5_MAX_LEN = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPARE,
    S_DONE,
    S_ERROR
  } state_t;

  function automatic logic len_ok(
    input logic [MD5_LEN_W-1:0] len
  );
    return (len != '0) &&
           (len <= MD5_LEN_W'(MD5_MAX_LEN));
  endfunction

endpackage

// File: rtl/md5_core_arbiter_if.sv
// md5_core_arbiter_if: requester bus between the candidate
// generators (master) and the arbiter (slave). Slot i of each
// packed vector belongs to requester i.
interface md5_core_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import md5_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*MD5_WORD_W-1:0] req_word;
  logic [NUM_REQ*MD5_LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (
    output req_valid,
    output req_word,
    output req_len,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_word,
    input  req_len,
    output req_ready
  );

endinterface

// File: rtl/md5_core_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker. Searches req from
// ptr+1 upward (wrapping); returns one-hot gnt, binary idx, any.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 4
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int i;

  // Walk from lowest to highest priority so that the
  // last hit written is the winner (closest to ptr+1).
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    i   = 0;
    for (int k = N; k >= 1; k--) begin
      i = (int'(ptr) + k) % N;
      if (en && req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDW'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/md5_core_arbiter.sv
// md5_core_arbiter: shares one MD5 core between NUM_REQ generators.
// Ports: clock/reset, req bus (valid/word/len/ready), target_hash,
// clear, core_* to/from the core, found_* match latch, last_digest,
// hash_count, busy, sticky timeout_err/len_err.
module md5_core_arbiter
  import md5_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024,
  parameter int IDW     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  md5_core_arbiter_if.slave     req,
  input  logic [MD5_WORD_W-1:0] target_hash,
  input  logic                  clear,
  output logic [MD5_WORD_W-1:0] core_word,
  output logic [MD5_LEN_W-1:0]  core_width,
  output logic                  core_in_valid,
  input  logic                  core_ready,
  input  logic [MD5_WORD_W-1:0] core_digest,
  input  logic                  core_out_valid,
  output logic                  found,
  output logic [MD5_WORD_W-1:0] found_word,
  output logic [MD5_LEN_W-1:0]  found_len,
  output logic [IDW-1:0]        found_id,
  output logic [MD5_WORD_W-1:0] last_digest,
  output logic [31:0]           hash_count,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  len_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                  state;
  logic [IDW-1:0]          ptr;
  logic [IDW-1:0]          cap_id;
  logic [TW-1:0]           tcnt;
  logic                    arb_en;
  logic [NUM_REQ-1:0]      gnt;
  logic [IDW-1:0]          gidx;
  logic                    gnt_any;
  logic [MD5_WORD_W-1:0]   sel_word;
  logic [MD5_LEN_W-1:0]    sel_len;

  assign arb_en = (state == S_IDLE) && core_ready && !reset;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr (
    .req (req.req_valid),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gidx),
    .any (gnt_any)
  );

  assign req.req_ready = gnt;

  assign busy = (state == S_ISSUE) ||
                (state == S_WAIT)  ||
                (state == S_COMPARE);

  always_comb begin
    sel_word = '0;
    sel_len  = '0;
    for (int s = 0; s < NUM_REQ; s++) begin
      if (gnt[s]) begin
        sel_word = req.req_word[s*MD5_WORD_W +: MD5_WORD_W];
        sel_len  = req.req_len[s*MD5_LEN_W +: MD5_LEN_W];
      end
    end
  end

  // core_word/core_width double as the captured candidate; they
  // are only rewritten on the next accepted transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      ptr           <= '0;
      cap_id        <= '0;
      tcnt          <= '0;
      core_word     <= '0;
      core_width    <= '0;
      core_in_valid <= 1'b0;
      found         <= 1'b0;
      found_word    <= '0;
      found_len     <= '0;
      found_id      <= '0;
      last_digest   <= '0;
      hash_count    <= '0;
      timeout_err   <= 1'b0;
      len_err       <= 1'b0;
    end else begin
      core_in_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (gnt_any) begin
            // ptr moves even on a rejected length so a faulty
            // requester cannot hold the core.
            ptr <= gidx;
            if (len_ok(sel_len)) begin
              core_word     <= sel_word;
              core_width    <= sel_len;
              cap_id        <= gidx;
              core_in_valid <= 1'b1;
              state         <= S_ISSUE;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_out_valid) begin
            last_digest <= core_digest;
            state       <= S_COMPARE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_COMPARE: begin
          hash_count <= hash_count + 32'd1;
          if (last_digest == target_hash) begin
            found      <= 1'b1;
            found_word <= core_word;
            found_len  <= core_width;
            found_id   <= cap_id;
            state      <= S_DONE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (clear) begin
            found      <= 1'b0;
            found_word <= '0;
            found_len  <= '0;
            found_id   <= '0;
            state      <= S_IDLE;
          end
        end
        S_ERROR: begin
          if (clear) begin
            timeout_err <= 1'b0;
            len_err     <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_core_arbiter.sv
// tb_md5_core_arbiter: directed bench for md5_core_arbiter with a
// behavioural 64-cycle core model and a TIMEOUT=16 second instance.
module tb_md5_core_arbiter;
  import md5_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 64;
  localparam logic [127:0] ABC_W =
    128'h6162_6300_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] ABC_H =
    128'h9001_5098_3cd2_4fb0_d696_3f7d_28e1_7f72;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [127:0] target_hash;
  logic         clear;
  logic [127:0] core_word;
  logic [7:0]   core_width;
  logic         core_in_valid;
  logic         core_ready;
  logic [127:0] core_digest;
  logic         core_out_valid;
  logic         found;
  logic [127:0] found_word;
  logic [7:0]   found_len;
  logic [3:0]   found_id;
  logic [127:0] last_digest;
  logic [31:0]  hash_count;
  logic         busy;
  logic         timeout_err;
  logic         len_err;

  logic         clear_t;
  logic [127:0] core_word_t;
  logic [7:0]   core_width_t;
  logic         core_in_valid_t;
  logic         core_ready_t;
  logic [127:0] core_digest_t;
  logic         core_out_valid_t;
  logic         found_t;
  logic [127:0] found_word_t;
  logic [7:0]   found_len_t;
  logic [3:0]   found_id_t;
  logic [127:0] last_digest_t;
  logic [31:0]  hash_count_t;
  logic         busy_t;
  logic         timeout_err_t;
  logic         len_err_t;

  md5_core_arbiter_if #(.NUM_REQ(N)) rif ();
  md5_core_arbiter_if #(.NUM_REQ(N)) rif_t ();

  md5_core_arbiter #(
    .NUM_REQ(N), .TIMEOUT(1024), .IDW(4)
  ) dut (
    .clock(clock), .reset(reset), .req(rif),
    .target_hash(target_hash), .clear(clear),
    .core_word(core_word), .core_width(core_width),
    .core_in_valid(core_in_valid), .core_ready(core_ready),
    .core_digest(core_digest),
    .core_out_valid(core_out_valid),
    .found(found), .found_word(found_word),
    .found_len(found_len), .found_id(found_id),
    .last_digest(last_digest), .hash_count(hash_count),
    .busy(busy), .timeout_err(timeout_err),
    .len_err(len_err)
  );

  md5_core_arbiter #(
    .NUM_REQ(N), .TIMEOUT(16), .IDW(4)
  ) dut_t (
    .clock(clock), .reset(reset), .req(rif_t),
    .target_hash(target_hash), .clear(clear_t),
    .core_word(core_word_t), .core_width(core_width_t),
    .core_in_valid(core_in_valid_t),
    .core_ready(core_ready_t),
    .core_digest(core_digest_t),
    .core_out_valid(core_out_valid_t),
    .found(found_t), .found_word(found_word_t),
    .found_len(found_len_t), .found_id(found_id_t),
    .last_digest(last_digest_t),
    .hash_count(hash_count_t),
    .busy(busy_t), .timeout_err(timeout_err_t),
    .len_err(len_err_t)
  );

  // Core model: answers LAT cycles after an issue; "abc" hashes
  // to its real MD5, anything else to the inverted word.
  logic [127:0] seen_word;
  initial begin
    core_out_valid = 1'b0;
    core_digest    = '0;
    seen_word      = '0;
    forever begin
      @(negedge clock);
      if (core_in_valid) begin
        seen_word = core_word;
        repeat (LAT - 1) @(negedge clock);
        core_digest = (seen_word == ABC_W) ? ABC_H : ~seen_word;
        core_out_valid = 1'b1;
        @(negedge clock);
        core_out_valid = 1'b0;
      end
    end
  end

  int civ_cnt = 0;
  int multi_cnt = 0;
  int ov_cnt = 0;
  always @(negedge clock) begin
    if (core_in_valid) civ_cnt++;
    if (core_out_valid) ov_cnt++;
    if ($countones(rif.req_ready) > 1) multi_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_grant(input string nm, output int id);
    id = -1;
    for (int t = 0; t < 300; t++) begin
      #1;
      if (|rif.req_ready) begin
        for (int g = 0; g < N; g++)
          if (rif.req_ready[g]) id = g;
        return;
      end
      @(negedge clock);
    end
    checks++;
    errors++;
    $display("FAIL %s: no grant in 300 cycles, expected one", nm);
  endtask

  task automatic wait_idle(input string nm);
    for (int t = 0; t < 300; t++) begin
      if (!busy) return;
      @(negedge clock);
    end
    checks++;
    errors++;
    $display("FAIL %s: busy after 300 cycles, expected 0", nm);
  endtask

  typedef struct {
    logic [3:0] valid;
    int         exp_id;
  } rr_vec_t;

  rr_vec_t vec [16];
  int      id;
  int      bad;
  int      c0;
  int      m0;
  int      o0;
  logic    ok;
  logic [127:0] wexp;

  initial begin
    for (int i = 0; i < 12; i++) begin
      vec[i].valid  = 4'b1111;
      vec[i].exp_id = (i + 1) % 4;
    end
    vec[12] = '{4'b1010, 1};
    vec[13] = '{4'b1010, 3};
    vec[14] = '{4'b0110, 1};
    vec[15] = '{4'b0001, 0};

    target_hash = ABC_H;
    clear = 1'b0;
    core_ready = 1'b1;
    rif.req_valid = '0;
    rif.req_word  = '0;
    rif.req_len   = '0;
    clear_t = 1'b0;
    core_ready_t = 1'b1;
    core_digest_t = '0;
    core_out_valid_t = 1'b0;
    rif_t.req_valid = '0;
    rif_t.req_word  = '0;
    rif_t.req_len   = '0;

    // Reset state and single "abc" match from requester 2
    do_reset();
    chk("rst_found", found, 0);
    chk("rst_hash_count", hash_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_in_valid", core_in_valid, 0);
    chk("rst_core_word", core_word, 0);
    chk("rst_last_digest", last_digest, 0);
    chk("rst_errs", {timeout_err, len_err}, 0);

    c0 = civ_cnt;
    rif.req_word[2*128 +: 128] = ABC_W;
    rif.req_len[2*8 +: 8] = 8'd3;
    rif.req_valid = 4'b0100;
    wait_grant("abc_grant", id);
    chk("abc_grant", id, 2);
    @(negedge clock);
    wait_idle("abc_idle");
    chk("abc_found", found, 1);
    chk("abc_found_id", found_id, 2);
    chk("abc_found_len", found_len, 3);
    chk("abc_found_word", found_word, ABC_W);
    chk("abc_hash_count", hash_count, 1);
    chk("abc_civ_pulses", civ_cnt - c0, 1);

    // DONE holds everything with all requesters valid
    rif.req_word[0*128 +: 128] = 128'h1111;
    rif.req_word[1*128 +: 128] = 128'h2222;
    rif.req_word[3*128 +: 128] = 128'h4444;
    rif.req_len = {8'd4, 8'd3, 8'd4, 8'd4};
    rif.req_valid = 4'b1111;
    bad = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock);
      if (rif.req_ready != 0 || !found || busy ||
          found_word != ABC_W || found_id != 4'd2 ||
          found_len != 8'd3)
        bad++;
    end
    chk("done_hold_bad_cycles", bad, 0);

    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr_found", found, 0);
    chk("clr_found_word", found_word, 0);
    chk("clr_found_id", found_id, 0);
    wait_grant("clr_grant", id);
    chk("clr_grant_next", id, 3);
    @(negedge clock);
    wait_idle("clr_idle");
    chk("clr_hash_count", hash_count, 2);
    rif.req_valid = '0;

    // Round-robin table
    target_hash = 128'h1;
    do_reset();
    m0 = multi_cnt;
    rif.req_word = {128'hDDDD, 128'hCCCC, 128'hBBBB, 128'hAAAA};
    rif.req_len  = {8'd16, 8'd1, 8'd2, 8'd1};
    for (int i = 0; i < 16; i++) begin
      rif.req_valid = vec[i].valid;
      wait_grant("rr_grant", id);
      chk($sformatf("rr_grant[%0d]", i), id, vec[i].exp_id);
      wexp = rif.req_word[vec[i].exp_id*128 +: 128];
      @(negedge clock);
      chk($sformatf("rr_word[%0d]", i), core_word, wexp);
      wait_idle("rr_idle");
      chk($sformatf("rr_count[%0d]", i), hash_count, i + 1);
    end
    rif.req_valid = '0;
    chk("rr_onehot_violations", multi_cnt - m0, 0);

    // Timeout on the TIMEOUT=16 instance
    do_reset();
    rif_t.req_word[127:0] = 128'h1234;
    rif_t.req_len[7:0] = 8'd4;
    rif_t.req_valid = 4'b0001;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clock);
      if (core_in_valid_t) ok = 1'b1;
    end
    chk("to_issue_seen", ok, 1);
    rif_t.req_valid = 4'b1111;
    repeat (16) @(negedge clock);
    chk("to_err_before", timeout_err_t, 0);
    chk("to_busy_before", busy_t, 1);
    @(negedge clock);
    chk("to_err_at16", timeout_err_t, 1);
    chk("to_busy_err", busy_t, 0);
    repeat (5) @(negedge clock);
    chk("to_ready_err", rif_t.req_ready, 0);
    clear_t = 1'b1;
    @(negedge clock);
    clear_t = 1'b0;
    chk("to_clr_err", timeout_err_t, 0);
    #1;
    chk("to_clr_idle_grant", |rif_t.req_ready, 1);
    rif_t.req_valid = '0;

    // Length rejection, plus core_ready gating
    do_reset();
    core_ready = 1'b0;
    rif.req_word = {128'h0, 128'h0, 128'h5555, 128'hBAD0};
    rif.req_len  = {8'd0, 8'd0, 8'd5, 8'd0};
    rif.req_valid = 4'b0001;
    repeat (3) @(negedge clock);
    chk("nordy_ready", rif.req_ready, 0);
    chk("nordy_len_err", len_err, 0);
    core_ready = 1'b1;
    wait_grant("len0_grant", id);
    chk("len0_grant", id, 0);
    @(negedge clock);
    chk("len0_len_err", len_err, 1);
    chk("len0_busy", busy, 0);
    do_reset();
    chk("len_rst_len_err", len_err, 0);
    c0 = civ_cnt;
    rif.req_len[7:0] = 8'd17;
    rif.req_valid = 4'b0001;
    wait_grant("len17_grant", id);
    chk("len17_grant", id, 0);
    @(negedge clock);
    chk("len17_len_err", len_err, 1);
    chk("len17_busy", busy, 0);
    rif.req_valid = 4'b0011;
    wait_grant("len5_grant", id);
    chk("len5_grant", id, 1);
    @(negedge clock);
    chk("len5_word", core_word, 128'h5555);
    wait_idle("len5_idle");
    chk("len_hash_count", hash_count, 1);
    chk("len_civ_pulses", civ_cnt - c0, 1);
    chk("len_err_sticky", len_err, 1);
    rif.req_valid = '0;

    // Reset during WAIT; the late digest must be ignored
    rif.req_word[2*128 +: 128] = 128'h7777;
    rif.req_len[2*8 +: 8] = 8'd4;
    rif.req_valid = 4'b0100;
    wait_grant("rw_grant", id);
    chk("rw_grant", id, 2);
    @(negedge clock);
    rif.req_valid = '0;
    o0 = ov_cnt;
    repeat (5) @(negedge clock);
    chk("rw_busy_wait", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rw_busy", busy, 0);
    chk("rw_core_word", core_word, 0);
    chk("rw_core_width", core_width, 0);
    chk("rw_hash_count", hash_count, 0);
    chk("rw_last_digest", last_digest, 0);
    chk("rw_len_err", len_err, 0);
    repeat (LAT + 10) @(negedge clock);
    chk("rw_late_valid_seen", ov_cnt - o0, 1);
    chk("rw_late_hash_count", hash_count, 0);
    chk("rw_late_digest", last_digest, 0);
    chk("rw_late_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim still running, expected finish");
    $fatal(1);
  end

endmodule
